// File: rtl/ensemble_vote_combiner.sv
// Joins three classifier AXI-Stream result streams through per-channel FIFOs and majority-votes the labels.
// Optional feature: define ENSEMBLE_VOTE_STATS_EN to add saturating per-category decision counters.
module ensemble_vote_combiner #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEEP_WIDTH  = 4,
  parameter int unsigned CLASS_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIE_IDX     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
`ifdef ENSEMBLE_VOTE_STATS_EN
  output logic [31:0]           stat_unanimous,
  output logic [31:0]           stat_majority,
  output logic [31:0]           stat_tie,
`endif
  output logic                  err_last_mismatch
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = CLASS_WIDTH + 1;
  localparam logic [1:0]  TIE_SEL = 2'(TIE_IDX);

  logic [2:0]             in_valid, in_last, in_ready, push, not_empty, head_last;
  logic [CLASS_WIDTH-1:0] in_lbl   [3];
  logic [CLASS_WIDTH-1:0] head_lbl [3];
  logic [ENT_W-1:0]       mem      [3][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr   [3];
  logic [PTR_W-1:0]       rd_ptr   [3];
  logic [CNT_W-1:0]       count    [3];

  logic                   pop_c, unan_c, tie_c, last_err_c;
  logic [CLASS_WIDTH-1:0] vote_lbl_c;
  logic [DATA_WIDTH-1:0]  vote_word_c;
  logic                   unused_inputs_c;

  // Only the label bits and tkeep-free payload matter downstream.
  assign unused_inputs_c = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                             s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                             s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                             s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

  // Channel bundling, FIFO flags and head extraction.
  always_comb begin
    in_valid  = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    in_last   = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    in_lbl[0] = s_axis_tdata_0[CLASS_WIDTH-1:0];
    in_lbl[1] = s_axis_tdata_1[CLASS_WIDTH-1:0];
    in_lbl[2] = s_axis_tdata_2[CLASS_WIDTH-1:0];
    in_ready  = '0;
    push      = '0;
    not_empty = '0;
    head_last = '0;
    for (int k = 0; k < 3; k++) begin
      in_ready[k]  = (count[k] != CNT_W'(FIFO_DEPTH));
      push[k]      = in_valid[k] & in_ready[k];
      not_empty[k] = (count[k] != '0);
      {head_last[k], head_lbl[k]} = mem[k][rd_ptr[k]];
    end
  end

  assign s_axis_tready_0 = in_ready[0];
  assign s_axis_tready_1 = in_ready[1];
  assign s_axis_tready_2 = in_ready[2];
  assign m_axis_tkeep    = {KEEP_WIDTH{m_axis_tvalid}};

  // All three channels pop together whenever the output register can take a decision.
  assign pop_c      = (&not_empty) & (~m_axis_tvalid | m_axis_tready);
  assign last_err_c = (head_last != 3'b000) && (head_last != 3'b111);

  // Majority vote with ch0 preference; TIE_IDX breaks a three-way split.
  always_comb begin
    vote_lbl_c  = head_lbl[0];
    tie_c       = 1'b0;
    unan_c      = (head_lbl[0] == head_lbl[1]) && (head_lbl[0] == head_lbl[2]);
    vote_word_c = '0;
    if ((head_lbl[0] == head_lbl[1]) || (head_lbl[0] == head_lbl[2])) begin
      vote_lbl_c = head_lbl[0];
    end else if (head_lbl[1] == head_lbl[2]) begin
      vote_lbl_c = head_lbl[1];
    end else begin
      vote_lbl_c = head_lbl[TIE_SEL];
      tie_c      = 1'b1;
    end
    vote_word_c[CLASS_WIDTH-1:0] = vote_lbl_c;
    vote_word_c[16]              = unan_c;
    vote_word_c[17]              = tie_c;
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= {in_last[k], in_lbl[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop_c)   rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + CNT_W'(push[k]) - CNT_W'(pop_c);
      end
    end
  end

  // Decision register: holds tdata/tlast while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tlast      <= 1'b0;
      err_last_mismatch <= 1'b0;
    end else begin
      if (pop_c) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= vote_word_c;
        m_axis_tlast  <= head_last[0];
        if (last_err_c) err_last_mismatch <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef ENSEMBLE_VOTE_STATS_EN
  // Saturating decision-category counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_unanimous <= '0;
      stat_majority  <= '0;
      stat_tie       <= '0;
    end else if (pop_c) begin
      if (unan_c) begin
        if (stat_unanimous != '1) stat_unanimous <= stat_unanimous + 32'd1;
      end else if (tie_c) begin
        if (stat_tie != '1) stat_tie <= stat_tie + 32'd1;
      end else begin
        if (stat_majority != '1) stat_majority <= stat_majority + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Self-checking bench for ensemble_vote_combiner: directed cases plus randomized skewed traffic
// scored against a queue-based vote model.
module tb_ensemble_vote_combiner;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TIE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata [3];
  logic [KW-1:0] s_tkeep [3];
  logic [2:0]    s_tvalid, s_tlast, s_tready;
  logic          s_tready_0, s_tready_1, s_tready_2;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_ready, m_tlast, err;
`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [31:0]   st_unan, st_maj, st_tie;
`endif

  always #5 clk = ~clk;
  assign s_tready = {s_tready_2, s_tready_1, s_tready_0};

  ensemble_vote_combiner #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .FIFO_DEPTH(DEPTH), .TIE_IDX(TIE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_0(s_tdata[0]), .s_axis_tkeep_0(s_tkeep[0]), .s_axis_tvalid_0(s_tvalid[0]),
    .s_axis_tready_0(s_tready_0), .s_axis_tlast_0(s_tlast[0]),
    .s_axis_tdata_1(s_tdata[1]), .s_axis_tkeep_1(s_tkeep[1]), .s_axis_tvalid_1(s_tvalid[1]),
    .s_axis_tready_1(s_tready_1), .s_axis_tlast_1(s_tlast[1]),
    .s_axis_tdata_2(s_tdata[2]), .s_axis_tkeep_2(s_tkeep[2]), .s_axis_tvalid_2(s_tvalid[2]),
    .s_axis_tready_2(s_tready_2), .s_axis_tlast_2(s_tlast[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_tlast),
`ifdef ENSEMBLE_VOTE_STATS_EN
    .stat_unanimous(st_unan), .stat_majority(st_maj), .stat_tie(st_tie),
`endif
    .err_last_mismatch(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference vote: any label held by two or more channels wins; otherwise the tie channel.
  function automatic logic [31:0] ref_vote(input int a, input int b, input int c);
    int lbl [3];
    int win;
    int cnt;
    logic [31:0] r;
    lbl[0] = a; lbl[1] = b; lbl[2] = c;
    win = -1;
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 3; j++) if (lbl[j] == lbl[i]) cnt++;
      if (cnt >= 2 && win < 0) win = lbl[i];
    end
    r = '0;
    if (win < 0) begin
      r     = 32'(lbl[TIE]);
      r[17] = 1'b1;
    end else begin
      r = 32'(win);
    end
    r[16] = (a == b) && (b == c);
    return r;
  endfunction

  // Stimulus sources and scoreboard state.
  logic [31:0] src_data [3][$];
  bit          src_last [3][$];
  int          mq_lbl   [3][$];
  bit          mq_last  [3][$];
  logic [31:0] exp_data [$];
  bit          exp_last [$];
  bit          err_exp;
  int          n_out, n_joined;
  int          cnt_unan, cnt_maj, cnt_tie;
  logic [2:0]  acc;
  bit          prev_stall, prev_last;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    int l0, l1, l2;
    bit t0, t1, t2;
    logic [31:0] w;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mq_lbl[k].delete();
        mq_last[k].delete();
      end
      exp_data.delete();
      exp_last.delete();
      err_exp = 0; acc = '0; prev_stall = 0;
      n_out = 0; n_joined = 0; cnt_unan = 0; cnt_maj = 0; cnt_tie = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      for (int k = 0; k < 3; k++) begin
        acc[k] = s_tvalid[k] & s_tready[k];
        if (acc[k]) begin
          mq_lbl[k].push_back(int'(s_tdata[k][CW-1:0]));
          mq_last[k].push_back(s_tlast[k]);
        end
      end
      while (mq_lbl[0].size() > 0 && mq_lbl[1].size() > 0 && mq_lbl[2].size() > 0) begin
        l0 = mq_lbl[0].pop_front(); l1 = mq_lbl[1].pop_front(); l2 = mq_lbl[2].pop_front();
        t0 = mq_last[0].pop_front(); t1 = mq_last[1].pop_front(); t2 = mq_last[2].pop_front();
        w = ref_vote(l0, l1, l2);
        exp_data.push_back(w);
        exp_last.push_back(t0);
        n_joined++;
        if (!(t0 == t1 && t1 == t2)) err_exp = 1;
        if (w[16]) cnt_unan++;
        else if (w[17]) cnt_tie++;
        else cnt_maj++;
      end
      if (m_tvalid && m_ready) begin
        n_out++;
        if (exp_data.size() == 0) begin
          check("spurious_out_count", 32'(n_out), 32'(n_joined));
        end else begin
          check("out_data", m_tdata, exp_data.pop_front());
          check("out_last", 32'(m_tlast), 32'(exp_last.pop_front()));
          check("out_keep", 32'(m_tkeep), 32'hF);
        end
      end
      prev_stall = m_tvalid && !m_ready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic fill(input int n, input int lmax, input int last_pct);
    int base, lbl;
    bit bl;
    for (int i = 0; i < n; i++) begin
      base = int'($urandom_range(lmax, 0));
      bl   = ($urandom_range(99, 0) < 20) || (i == n - 1);
      for (int k = 0; k < 3; k++) begin
        lbl = ($urandom_range(2, 0) == 0) ? int'($urandom_range(lmax, 0)) : base;
        src_data[k].push_back(($urandom() & 32'hFFFF_FF00) | 32'(lbl));
        src_last[k].push_back(($urandom_range(99, 0) < last_pct) ? bit'($urandom_range(1, 0)) : bl);
      end
    end
  endtask

  // Streams the source queues with per-channel valid probability until fully drained.
  task automatic pump(input int vp0, input int vp1, input int vp2, input int rp, input int stall);
    int vp [3];
    int cyc;
    bit done;
    vp[0] = vp0; vp[1] = vp1; vp[2] = vp2;
    cyc = 0; done = 0;
    while (cyc < 4000 && !done) begin
      @(posedge clk); #1;
      if (stall > 0 && cyc == stall) begin
        check("stall_tready", 32'(s_tready), 32'd0);
        check("stall_tvalid", 32'(m_tvalid), 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
        if (s_tvalid[k] && acc[k]) s_tvalid[k] = 1'b0;
        if (!s_tvalid[k] && src_data[k].size() > 0 && $urandom_range(99, 0) < vp[k]) begin
          s_tdata[k]  = src_data[k].pop_front();
          s_tlast[k]  = src_last[k].pop_front();
          s_tvalid[k] = 1'b1;
        end
      end
      m_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99, 0) < rp);
      cyc++;
      done = (src_data[0].size() == 0) && (src_data[1].size() == 0) && (src_data[2].size() == 0)
             && (s_tvalid == 3'b000) && (exp_data.size() == 0);
    end
    check("pump_done", 32'(done), 32'd1);
    s_tvalid = '0;
    m_ready  = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_err"}, 32'(err), 32'(err_exp));
    check({tag, "_idle_valid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_tready"}, 32'(s_tready), 32'h7);
    check({tag, "_count"}, 32'(n_out), 32'(n_joined));
`ifdef ENSEMBLE_VOTE_STATS_EN
    check({tag, "_stat_unan"}, st_unan, 32'(cnt_unan));
    check({tag, "_stat_maj"}, st_maj, 32'(cnt_maj));
    check({tag, "_stat_tie"}, st_tie, 32'(cnt_tie));
`endif
  endtask

  task automatic one_sample(input int l0, input int l1, input int l2, input logic [31:0] exp_word);
    @(posedge clk); #1;
    s_tdata[0] = ($urandom() & 32'hFFFF_FF00) | 32'(l0);
    s_tdata[1] = ($urandom() & 32'hFFFF_FF00) | 32'(l1);
    s_tdata[2] = ($urandom() & 32'hFFFF_FF00) | 32'(l2);
    s_tlast  = 3'b000;
    s_tvalid = 3'b111;
    m_ready  = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 3'b000;
    check("lat_n1_valid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", 32'(m_tvalid), 32'd1);
    check("vote_word", m_tdata, exp_word);
    @(posedge clk); #1;
    check("valid_drop", 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    int base_out;
    rst_n = 1'b0; s_tvalid = '0; s_tlast = '0; m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tdata[k] = '0;
      s_tkeep[k] = 4'(k + 5);
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_tready", 32'(s_tready), 32'h7);
    m_ready = 1'b1;

    one_sample(3, 3, 3, 32'h0001_0003);
    one_sample(5, 7, 5, 32'h0000_0005);
    one_sample(1, 2, 3, 32'h0002_0003);
    one_sample(9, 4, 4, 32'h0000_0004);
    check_quiet("directed");

    // ch0 leads by a full FIFO while the others idle.
    base_out = n_out;
    for (int i = 0; i < 4; i++) begin
      s_tdata[0] = 32'(10 + i); s_tvalid = 3'b001;
      @(posedge clk); #1;
    end
    s_tvalid = '0;
    check("skew_tready0", 32'(s_tready[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("skew_no_out", 32'(m_tvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s_tdata[1] = 32'(10 + i); s_tdata[2] = 32'(20 + i); s_tvalid = 3'b110;
      @(posedge clk); #1;
    end
    s_tvalid = '0;
    repeat (6) @(posedge clk);
    #1;
    check("skew_out_count", 32'(n_out - base_out), 32'd4);
    check_quiet("skew");

    // Output stalled with six samples queued per channel.
    fill(6, 3, 0);
    pump(100, 100, 100, 100, 10);
    check_quiet("stall");

    // tlast only on ch0 for sample 2.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        src_data[k].push_back(32'(i + k));
        src_last[k].push_back((k == 0) && (i == 2));
      end
    end
    pump(100, 100, 100, 100, 0);
    check("tlast_err_sticky", 32'(err), 32'd1);
    check_quiet("tlast");

    // Reset with samples buffered and inputs still valid.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) s_tdata[k] = 32'(40 + i);
      s_tvalid = 3'b111;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) s_tdata[k] = 32'd77;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_tdata", m_tdata, 32'd0);
    s_tvalid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("postrst_tvalid", 32'(m_tvalid), 32'd0);
    check("postrst_no_out", 32'(n_out), 32'd0);
    check_quiet("postrst");

    fill(30, 3, 10);
    pump(70, 60, 50, 60, 0);
    check_quiet("rand_a");
    fill(30, 255, 0);
    pump(100, 25, 90, 85, 0);
    check_quiet("rand_b");
    fill(25, 1, 30);
    pump(90, 90, 90, 30, 0);
    check_quiet("rand_c");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
